// File: rtl/ls377_regbank.sv
// Register bank with one write-port operation per enabled cycle (LOAD/INC/DEC/CLR),
// two combinational read ports with optional LOAD bypass, carry/zero flags and a display tap.
module ls377_regbank #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int AW      = $clog2(DEPTH),
    parameter bit BYPASS  = 1'b1,
    parameter bit R0_ZERO = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EN,
    input  logic [1:0]       op,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] D,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] qa,
    output logic [WIDTH-1:0] qb,
    input  logic [AW-1:0]    show_sel,
    output logic [WIDTH-1:0] Dshow,
    output logic             carry,
    output logic             zero
);

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_INC  = 2'b01,
        OP_DEC  = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [WIDTH-1:0] cur_val;
    logic [WIDTH-1:0] result;
    logic             carry_nxt;
    logic             zero_nxt;
    logic             wr_en;
    logic             bypass_live;

    assign cur_val = mem[waddr];

    always_comb begin
        result    = '0;
        carry_nxt = 1'b0;
        unique case (op_e'(op))
            OP_LOAD: begin
                result    = D;
                carry_nxt = 1'b0;
            end
            OP_INC: begin
                result    = cur_val + 1'b1;
                carry_nxt = &cur_val;
            end
            OP_DEC: begin
                result    = cur_val - 1'b1;
                carry_nxt = ~|cur_val;
            end
            OP_CLR: begin
                result    = '0;
                carry_nxt = 1'b0;
            end
            default: begin
                result    = '0;
                carry_nxt = 1'b0;
            end
        endcase
    end

    // zero reflects the op result even when a hardwired-zero register discards the write
    assign zero_nxt = (result == '0);
    assign wr_en    = EN && !(R0_ZERO && (waddr == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            carry <= 1'b0;
            zero  <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[waddr] <= result;
            end
            if (EN) begin
                carry <= carry_nxt;
                zero  <= zero_nxt;
            end
        end
    end

    // bypass is gated by rst so reads stay 0 throughout reset
    assign bypass_live = BYPASS && rst && EN && (op_e'(op) == OP_LOAD);

    always_comb begin
        qa = mem[raddr_a];
        if (R0_ZERO && (raddr_a == '0)) begin
            qa = '0;
        end else if (bypass_live && (raddr_a == waddr)) begin
            qa = D;
        end
    end

    always_comb begin
        qb = mem[raddr_b];
        if (R0_ZERO && (raddr_b == '0)) begin
            qb = '0;
        end else if (bypass_live && (raddr_b == waddr)) begin
            qb = D;
        end
    end

    assign Dshow = mem[show_sel];

endmodule
